alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter that shares the single combinational `alu` between two requesters, e.g. the execute stage and a multi-cycle address/compare unit. Each requester presents an opcode and two operands with a valid/ready handshake. The arbiter drives the ALU from the granted request, captures the result into a response register, and returns it on that requester's response channel with its own valid/ready handshake. Sustained throughput is one operation per cycle when the response consumer is always ready.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): operand/result width.
- `OP_WIDTH`, default 6: ALU opcode width; encodings are the shared `OP_ALU_*` defines.
- `CNT_WIDTH`, default 16: completed-operation counter width.

Ports:
- `i_clk` in 1: single clock; all state updates on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_req0_valid` in 1, `o_req0_ready` out 1, `i_req0_op` in OP_WIDTH, `i_req0_a` in DATA_WIDTH, `i_req0_b` in DATA_WIDTH: requester 0 command channel.
- `i_req1_valid`, `o_req1_ready`, `i_req1_op`, `i_req1_a`, `i_req1_b`: requester 1 command channel, same widths.
- `o_rsp0_valid` out 1, `i_rsp0_ready` in 1, `o_rsp0_data` out DATA_WIDTH: requester 0 response.
- `o_rsp1_valid`, `i_rsp1_ready`, `o_rsp1_data`: requester 1 response, same widths.
- `o_alu_op` out OP_WIDTH, `o_alu_a` out DATA_WIDTH, `o_alu_b` out DATA_WIDTH: drive `alu` `i_alu_op`/`i_a`/`i_b`.
- `i_alu_c` in DATA_WIDTH: from `alu` `o_c`.
- `o_busy` out 1: response register occupied.
- `o_ops_count` out CNT_WIDTH: completed responses, wraps modulo 2^CNT_WIDTH.

## Operation
- States: IDLE (response register empty) and RESP (result held for `rsp_owner`).
- Free condition: `free = (state==IDLE) | (state==RESP & o_rspX_valid & i_rspX_ready)`, where X is `rsp_owner`.
- Grant, combinational:
  - Only one valid request: grant it.
  - Both valid: grant the requester that was not `last_grant`.
  - Neither valid: no grant.
- `o_reqN_ready = free & grant==N`. The ungranted requester's ready is 0.
- ALU drive: with a grant, `o_alu_*` = granted requester's op/a/b. With no grant, all zero.
- Accept (valid & ready) at an edge:
  - `rsp_data <= i_alu_c`
  - `rsp_owner <= N`
  - `last_grant <= N`
  - state becomes/stays RESP
- Response handshake with no new accept: state goes to IDLE.
- Response handshake and accept in the same cycle: stay in RESP with the new owner and data.
- `o_rspN_valid = (state==RESP) & rsp_owner==N`. Both `o_rsp*_data` show `rsp_data`.
- `o_ops_count` increments by 1 on every response handshake and wraps to 0.
- `o_busy = (state==RESP)`.
- Reset values: state IDLE, `last_grant=1` (requester 0 wins the first tie), `rsp_data=0`, `rsp_owner=0`, `o_ops_count=0`.
  - All outputs are therefore 0 after reset, except `o_reqN_ready`, which follows the grant logic.
- Reset mid-operation: the pending response is discarded with no handshake and no count. The requester must reissue.
- Undefined opcodes are passed through unchanged; the result is whatever `alu` returns.

## Timing
- Request to response latency: 1 cycle. Accept at edge k gives `o_rspN_valid=1` from edge k, with data equal to `i_alu_c` sampled at k.
- `o_reqN_ready` is combinational from state, valids and `i_rsp*_ready`. It must not depend on `i_reqN_valid` of the same requester beyond the grant.
- Requester and consumer rules:
  - A requester holds op/a/b stable while valid and not ready.
  - Response valid and data stay stable until the handshake.
- Back-pressure: while RESP and the owner's ready is low, both request readys are 0 and the ALU outputs are zero unless a grant exists. The grant is still computed, but no accept happens.

## Test plan
- **Single ADD.** After reset, req0 ADD a=1, b=1 for 1 cycle with rsp0_ready=1.
  - Next cycle: rsp0_valid=1, data=0x00000002.
  - rsp1_valid stays 0.
  - Count becomes 1 after the handshake.
- **Tie after reset.** req0 SUB 1,1 and req1 OR 0x00000101, 0x00010001, both valid, consumers ready.
  - req0 is accepted first: rsp0=0x00000000.
  - req1 is accepted the following cycle: rsp1=0x00010101.
- **Fairness.** Both requesters continuously valid, consumers always ready, 6 cycles.
  - Accept order is 0,1,0,1,0,1, one accept per cycle.
  - Count reaches 6.
- **Back-pressure.** req1 SRA 0xfffffff0 by 3 is accepted; rsp1_ready is held low 3 cycles.
  - rsp1_valid stays 1 with data 0xfffffffe throughout.
  - Both req readys stay 0 and req0 waits.
  - When rsp1_ready rises, req0 is accepted in the same cycle.
- **Reset mid-operation.** With a pending response for req1 SRA 0x80000000 by 0x1f (data 0xffffffff), assert i_rst for 1 cycle.
  - Next cycle: both rsp valids 0, o_busy 0, count 0.
  - A subsequent tie is granted to req0.
- **Counter wrap.** Run with CNT_WIDTH=4 for 17 handshakes; o_ops_count reads 1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two
//            requesters, with a single registered response slot.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module alu_share_arbiter #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int OP_WIDTH   = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [OP_WIDTH-1:0]   i_req0_op,
    input  logic [DATA_WIDTH-1:0] i_req0_a,
    input  logic [DATA_WIDTH-1:0] i_req0_b,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [OP_WIDTH-1:0]   i_req1_op,
    input  logic [DATA_WIDTH-1:0] i_req1_a,
    input  logic [DATA_WIDTH-1:0] i_req1_b,
    output logic                  o_rsp0_valid,
    input  logic                  i_rsp0_ready,
    output logic [DATA_WIDTH-1:0] o_rsp0_data,
    output logic                  o_rsp1_valid,
    input  logic                  i_rsp1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp1_data,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    input  logic [DATA_WIDTH-1:0] i_alu_c,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_ops_count
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RESP = 1'b1;

    logic [0:0]            r_state_q,      w_state_d;
    logic                  r_owner_q,      w_owner_d;
    logic                  r_last_grant_q, w_last_grant_d;
    logic [DATA_WIDTH-1:0] r_data_q,       w_data_d;
    logic [CNT_WIDTH-1:0]  r_count_q,      w_count_d;

    logic w_rsp_hs;
    logic w_free;
    logic w_gnt_valid;
    logic w_gnt_id;
    logic w_accept;

    // The slot frees up in the same cycle its current response is consumed,
    // which is what allows one operation per cycle.
    assign w_rsp_hs = (r_state_q == c_S_RESP) &
                      (r_owner_q ? i_rsp1_ready : i_rsp0_ready);
    assign w_free   = (r_state_q == c_S_IDLE) | w_rsp_hs;

    always_comb begin
        w_gnt_valid = i_req0_valid | i_req1_valid;
        w_gnt_id    = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            w_gnt_id = ~r_last_grant_q;
        end else if (i_req1_valid) begin
            w_gnt_id = 1'b1;
        end
    end

    assign w_accept     = w_free & w_gnt_valid;
    assign o_req0_ready = w_free & w_gnt_valid & ~w_gnt_id;
    assign o_req1_ready = w_free & w_gnt_valid &  w_gnt_id;

    always_comb begin
        o_alu_op = '0;
        o_alu_a  = '0;
        o_alu_b  = '0;
        if (w_gnt_valid) begin
            o_alu_op = w_gnt_id ? i_req1_op : i_req0_op;
            o_alu_a  = w_gnt_id ? i_req1_a  : i_req0_a;
            o_alu_b  = w_gnt_id ? i_req1_b  : i_req0_b;
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_owner_d      = r_owner_q;
        w_last_grant_d = r_last_grant_q;
        w_data_d       = r_data_q;
        w_count_d      = r_count_q;
        if (w_accept) begin
            w_state_d      = c_S_RESP;
            w_owner_d      = w_gnt_id;
            w_last_grant_d = w_gnt_id;
            w_data_d       = i_alu_c;
        end else if (w_rsp_hs) begin
            w_state_d = c_S_IDLE;
        end
        if (w_rsp_hs) begin
            w_count_d = r_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q      <= c_S_IDLE;
            r_owner_q      <= 1'b0;
            r_last_grant_q <= 1'b1;
            r_data_q       <= '0;
            r_count_q      <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_owner_q      <= w_owner_d;
            r_last_grant_q <= w_last_grant_d;
            r_data_q       <= w_data_d;
            r_count_q      <= w_count_d;
        end
    end

    assign o_rsp0_valid = (r_state_q == c_S_RESP) & ~r_owner_q;
    assign o_rsp1_valid = (r_state_q == c_S_RESP) &  r_owner_q;
    assign o_rsp0_data  = r_data_q;
    assign o_rsp1_data  = r_data_q;
    assign o_busy       = (r_state_q == c_S_RESP);
    assign o_ops_count  = r_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed self-checking bench for alu_share_arbiter with a small
//            behavioural ALU closing the loop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

    localparam logic [5:0] c_OP_ADD = 6'd0;
    localparam logic [5:0] c_OP_SUB = 6'd1;
    localparam logic [5:0] c_OP_OR  = 6'd2;
    localparam logic [5:0] c_OP_SRA = 6'd3;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [5:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_ready, rsp1_ready;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_c;
    logic [5:0]  alu_op;
    logic [15:0] ops_count;

    logic        w4_req0_ready, w4_req1_ready, w4_rsp0_valid, w4_rsp1_valid, w4_busy;
    logic [31:0] w4_rsp0_data, w4_rsp1_data, w4_alu_a, w4_alu_b, w4_alu_c;
    logic [5:0]  w4_alu_op;
    logic [3:0]  w4_ops_count;

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic logic [31:0] alu_model(input logic [5:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            c_OP_ADD: return a + b;
            c_OP_SUB: return a - b;
            c_OP_OR:  return a | b;
            c_OP_SRA: return $unsigned($signed(a) >>> b[4:0]);
            default:  return 32'h0;
        endcase
    endfunction

    assign alu_c    = alu_model(alu_op, alu_a, alu_b);
    assign w4_alu_c = alu_model(w4_alu_op, w4_alu_a, w4_alu_b);

    alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(6), .CNT_WIDTH(16)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_op(req0_op), .i_req0_a(req0_a), .i_req0_b(req0_b),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_op(req1_op), .i_req1_a(req1_a), .i_req1_b(req1_b),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(rsp0_data),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(rsp1_data),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .i_alu_c(alu_c),
        .o_busy(busy), .o_ops_count(ops_count)
    );

    alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(6), .CNT_WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(w4_req0_ready),
        .i_req0_op(req0_op), .i_req0_a(req0_a), .i_req0_b(req0_b),
        .i_req1_valid(req1_valid), .o_req1_ready(w4_req1_ready),
        .i_req1_op(req1_op), .i_req1_a(req1_a), .i_req1_b(req1_b),
        .o_rsp0_valid(w4_rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(w4_rsp0_data),
        .o_rsp1_valid(w4_rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(w4_rsp1_data),
        .o_alu_op(w4_alu_op), .o_alu_a(w4_alu_a), .o_alu_b(w4_alu_b), .i_alu_c(w4_alu_c),
        .o_busy(w4_busy), .o_ops_count(w4_ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_valids: got %b expected 000", {rsp0_valid, rsp1_valid, busy});
        end
        tests_run++;
        if (ops_count !== 16'd0 || rsp0_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_count_data: got cnt=%0d data=%h expected 0/0", ops_count, rsp0_data);
        end
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b00 || alu_op !== 6'd0 || alu_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_ready_alu: got rdy=%b op=%h a=%h expected 00/0/0",
                     {req0_ready, req1_ready}, alu_op, alu_a);
        end
    endtask

    task automatic test_single_add();
        do_reset();
        req0_valid = 1'b1; req0_op = c_OP_ADD; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || alu_a !== 32'd1 || alu_op !== c_OP_ADD) begin
            tests_failed++;
            $display("FAIL add_grant: got rdy=%b a=%h op=%h expected 1/1/0", req0_ready, alu_a, alu_op);
        end
        step();
        req0_valid = 1'b0;
        tests_run++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h2 || rsp1_valid !== 1'b0 || ops_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL add_resp: got v0=%b d=%h v1=%b cnt=%0d expected 1/00000002/0/0",
                     rsp0_valid, rsp0_data, rsp1_valid, ops_count);
        end
        step();
        tests_run++;
        if (ops_count !== 16'd1 || busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_count: got cnt=%0d busy=%b v0=%b expected 1/0/0", ops_count, busy, rsp0_valid);
        end
    endtask

    task automatic test_tie();
        do_reset();
        req0_valid = 1'b1; req0_op = c_OP_SUB; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = c_OP_OR;  req1_a = 32'h0000_0101; req1_b = 32'h0001_0001;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL tie_first_grant: got rdy=%b expected 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        tests_run++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0 || rsp1_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_rsp0: got v0=%b d=%h v1=%b expected 1/00000000/0", rsp0_valid, rsp0_data, rsp1_valid);
        end
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL tie_second_ready: got %b expected 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        tests_run++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h0001_0101 || rsp0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_rsp1: got v1=%b d=%h v0=%b expected 1/00010101/0", rsp1_valid, rsp1_data, rsp0_valid);
        end
        step();
        tests_run++;
        if (ops_count !== 16'd2 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_count: got cnt=%0d busy=%b expected 2/0", ops_count, busy);
        end
    endtask

    task automatic test_fairness();
        logic exp_owner;
        do_reset();
        req0_valid = 1'b1; req0_op = c_OP_ADD; req0_a = 32'd10; req0_b = 32'd0;
        req1_valid = 1'b1; req1_op = c_OP_ADD; req1_a = 32'd20; req1_b = 32'd0;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_owner = k[0];
            tests_run++;
            if (rsp0_valid !== ~exp_owner || rsp1_valid !== exp_owner ||
                rsp0_data !== (exp_owner ? 32'd20 : 32'd10) || ops_count !== 16'(k)) begin
                tests_failed++;
                $display("FAIL fair_accept_%0d: got v0=%b v1=%b d=%h cnt=%0d expected owner %0d cnt %0d",
                         k, rsp0_valid, rsp1_valid, rsp0_data, ops_count, exp_owner, k);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        tests_run++;
        if (ops_count !== 16'd6 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fair_count: got cnt=%0d busy=%b expected 6/0", ops_count, busy);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = c_OP_SRA; req1_a = 32'hffff_fff0; req1_b = 32'd3;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = c_OP_ADD; req0_a = 32'd5; req0_b = 32'd6;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== 32'hffff_fffe ||
                {req0_ready, req1_ready} !== 2'b00 || ops_count !== 16'd0) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got v1=%b d=%h rdy=%b cnt=%0d expected 1/fffffffe/00/0",
                         k, rsp1_valid, rsp1_data, {req0_ready, req1_ready}, ops_count);
            end
            if (k < 2) step();
        end
        rsp1_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b expected 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        tests_run++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd11 || rsp1_valid !== 1'b0 || ops_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL bp_next: got v0=%b d=%h v1=%b cnt=%0d expected 1/0000000b/0/1",
                     rsp0_valid, rsp0_data, rsp1_valid, ops_count);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = c_OP_SRA; req1_a = 32'h8000_0000; req1_b = 32'h1f;
        step();
        req1_valid = 1'b0;
        tests_run++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'hffff_ffff) begin
            tests_failed++;
            $display("FAIL mid_pending: got v1=%b d=%h expected 1/ffffffff", rsp1_valid, rsp1_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp1_ready = 1'b1;
        #1;
        tests_run++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b000 || ops_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_cleared: got v=%b cnt=%0d expected 000/0", {rsp0_valid, rsp1_valid, busy}, ops_count);
        end
        req0_valid = 1'b1; req0_op = c_OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = c_OP_ADD; req1_a = 32'd3; req1_b = 32'd4;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tests_run++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd3) begin
            tests_failed++;
            $display("FAIL mid_tie: got v0=%b d=%h expected 1/00000003", rsp0_valid, rsp0_data);
        end
        step();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        req0_valid = 1'b1; req0_op = c_OP_ADD; req0_a = 32'd7; req0_b = 32'd1;
        for (int k = 0; k < 17; k++) step();
        req0_valid = 1'b0;
        step();
        tests_run++;
        if (w4_ops_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL wrap_cnt4: got %0d expected 1", w4_ops_count);
        end
        tests_run++;
        if (ops_count !== 16'd17) begin
            tests_failed++;
            $display("FAIL wrap_cnt16: got %0d expected 17", ops_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_add();
        test_tie();
        test_fairness();
        test_back_pressure();
        test_reset_mid();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
